// File: rtl/vdmem_ctrl_if.sv
// Request/response bus between the vector load/store unit (master) and the
// vector data memory controller (slave).
interface vdmem_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int VECT_SIZE  = 8,
  parameter int ELEM_SIZE  = 8
);
  localparam int LW = VECT_SIZE * ELEM_SIZE;

  logic                  clr;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [VECT_SIZE-1:0]  req_mask;
  logic [LW-1:0]         req_wd;
  logic                  resp_valid;
  logic [LW-1:0]         resp_rd;
  logic                  resp_err;
  logic                  busy;

  modport master (
    output clr, req_valid, req_we, req_addr, req_mask, req_wd,
    input  req_ready, resp_valid, resp_rd, resp_err, busy
  );

  modport slave (
    input  clr, req_valid, req_we, req_addr, req_mask, req_wd,
    output req_ready, resp_valid, resp_rd, resp_err, busy
  );
endinterface

// File: rtl/vdmem_ctrl.sv
// Vector data memory: per-element masked writes, registered one-cycle read,
// out-of-range error reporting and a clear engine that zeroes every line.
module vdmem_ctrl #(
  parameter int MEMO_LINES = 64,
  parameter int VECT_SIZE  = 8,
  parameter int ELEM_SIZE  = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  vdmem_ctrl_if.slave bus
);
  localparam int LW   = VECT_SIZE * ELEM_SIZE;
  localparam int OFFS = $clog2(LW / 8);
  localparam int IW   = $clog2(MEMO_LINES);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;

  logic [LW-1:0]         mem [MEMO_LINES];

  logic [ADDR_WIDTH-1:0] line_addr;
  logic                  in_range;
  logic [IW-1:0]         idx;
  logic                  accept;
  logic [LW-1:0]         old_line;
  logic [LW-1:0]         merged;

  logic [VECT_SIZE-1:0]  wr_en;
  logic [IW-1:0]         wr_idx;
  logic [LW-1:0]         wr_data;

  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [LW-1:0]         resp_rd_q;

  // Full shifted address is kept so the upper bits take part in the range check.
  assign line_addr = bus.req_addr >> OFFS;
  assign in_range  = line_addr < ADDR_WIDTH'(MEMO_LINES);
  assign idx       = line_addr[IW-1:0];
  assign accept    = bus.req_valid && (state_q == ST_IDLE);
  assign old_line  = mem[idx];

  generate
    for (genvar gi = 0; gi < VECT_SIZE; gi++) begin : g_merge
      assign merged[gi*ELEM_SIZE +: ELEM_SIZE] =
        (bus.req_we && bus.req_mask[gi]) ? bus.req_wd[gi*ELEM_SIZE +: ELEM_SIZE]
                                         : old_line[gi*ELEM_SIZE +: ELEM_SIZE];
    end
  endgenerate

  always_comb begin
    wr_en   = '0;
    wr_idx  = idx;
    wr_data = merged;
    if (state_q == ST_CLEAR) begin
      wr_en   = '1;
      wr_idx  = ptr_q;
      wr_data = '0;
    end else if (accept && bus.req_we && in_range) begin
      wr_en = bus.req_mask;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < VECT_SIZE; i++) begin
      if (wr_en[i]) begin
        mem[wr_idx][i*ELEM_SIZE +: ELEM_SIZE] <= wr_data[i*ELEM_SIZE +: ELEM_SIZE];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + IW'(1);
        if (ptr_q == IW'(MEMO_LINES - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A request presented alongside clr is still accepted on this edge.
        if (bus.clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= '0;
    end else begin
      resp_valid_q <= accept;
      resp_err_q   <= accept && !in_range;
      if (accept) begin
        resp_rd_q <= in_range ? merged : '0;
      end
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q == ST_CLEAR);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rd    = resp_rd_q;
endmodule

// File: tb/tb_vdmem_ctrl.sv
// Self-checking bench for vdmem_ctrl: directed scenarios plus randomized
// traffic compared against an array-based reference of the memory contents.
module tb_vdmem_ctrl;
  localparam int LINES = 64;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vdmem_ctrl_if #(.ADDR_WIDTH(AW), .VECT_SIZE(8), .ELEM_SIZE(8)) bus ();

  vdmem_ctrl #(
    .MEMO_LINES(LINES),
    .VECT_SIZE (8),
    .ELEM_SIZE (8),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [63:0] ref_mem [LINES];
  logic [63:0] last_rd;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_req(input logic we, input logic [31:0] addr,
                                            input logic [7:0] mask, input logic [63:0] wd,
                                            output logic err);
    int unsigned line;
    line = addr / 8;
    if (line >= LINES) begin
      err = 1'b1;
      return 64'h0;
    end
    err = 1'b0;
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) ref_mem[line][i*8 +: 8] = wd[i*8 +: 8];
      end
    end
    return ref_mem[line];
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [7:0] mask,
                        input logic [63:0] wd, input logic clr_in, input string tag);
    logic [63:0] exp;
    logic        exp_err;
    @(negedge clk);
    chk({tag, "/ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_mask  = mask;
    bus.req_wd    = wd;
    bus.clr       = clr_in;
    exp = model_req(we, addr, mask, wd, exp_err);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.clr       = 1'b0;
    chk({tag, "/valid"}, 64'(bus.resp_valid), 64'd1);
    chk({tag, "/rd"}, bus.resp_rd, exp);
    chk({tag, "/err"}, 64'(bus.resp_err), 64'(exp_err));
    last_rd = exp;
    $display("%s %s addr=%h mask=%h wd=%h -> rd=%h err=%0b", tag, we ? "WR" : "RD",
             addr, mask, wd, bus.resp_rd, bus.resp_err);
  endtask

  task automatic idle_chk(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "/pulse"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "/hold"}, bus.resp_rd, last_rd);
    $display("%s idle rd=%h", tag, bus.resp_rd);
  endtask

  // Counts edges from the current point until req_ready rises; a clear must take 64.
  task automatic wait_clear(input string tag);
    int cnt = 0;
    int busy_bad = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      if (!bus.req_ready && !bus.busy) busy_bad++;
    end while (!bus.req_ready && cnt < 300);
    chk({tag, "/clear_cycles"}, 64'(cnt), 64'(LINES));
    chk({tag, "/busy_during"}, 64'(busy_bad), 64'd0);
    chk({tag, "/busy_after"}, 64'(bus.busy), 64'd0);
    for (int i = 0; i < LINES; i++) ref_mem[i] = 64'h0;
    $display("%s clear took %0d cycles", tag, cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] addr;
    logic [63:0] wd;
    bus.clr = 1'b0; bus.req_valid = 1'b0; bus.req_we = 1'b0;
    bus.req_addr = '0; bus.req_mask = '0; bus.req_wd = '0;
    last_rd = 64'h0;

    #12;
    chk("rst/ready", 64'(bus.req_ready), 64'd0);
    chk("rst/busy", 64'(bus.busy), 64'd1);
    chk("rst/valid", 64'(bus.resp_valid), 64'd0);
    chk("rst/err", 64'(bus.resp_err), 64'd0);
    chk("rst/rd", bus.resp_rd, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_clear("boot");

    // Fill three lines with ones, reset mid-response, then confirm they read zero.
    do_req(1'b1, 32'd0,      8'hFF, '1, 1'b0, "pre0");
    do_req(1'b1, 32'd31 * 8, 8'hFF, '1, 1'b0, "pre31");
    do_req(1'b1, 32'd63 * 8, 8'hFF, '1, 1'b0, "pre63");
    rst = 1'b1;
    #1;
    chk("rst_mid/valid_drop", 64'(bus.resp_valid), 64'd0);
    chk("rst_mid/rd", bus.resp_rd, 64'd0);
    last_rd = 64'h0;
    @(negedge clk);
    rst = 1'b0;
    wait_clear("rst");
    do_req(1'b0, 32'd0,      8'h00, '0, 1'b0, "rd0");
    do_req(1'b0, 32'd31 * 8, 8'h00, '0, 1'b0, "rd31");
    do_req(1'b0, 32'd63 * 8, 8'h00, '0, 1'b0, "rd63");

    do_req(1'b1, 32'h10, 8'hFF, 64'h8877665544332211, 1'b0, "wr2");
    do_req(1'b0, 32'h10, 8'h00, 64'h0, 1'b0, "rd2");
    chk("rd2/literal", bus.resp_rd, 64'h8877665544332211);
    idle_chk("after_rd2");
    do_req(1'b1, 32'h10, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, "mwr2");
    chk("mwr2/literal", bus.resp_rd, 64'h88776655AAAAAAAA);
    do_req(1'b0, 32'h13, 8'h00, 64'h0, 1'b0, "rd_mis");
    do_req(1'b1, 32'h10, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "nop_wr");
    do_req(1'b1, 32'h200, 8'hFF, 64'h1234, 1'b0, "oor_wr");
    do_req(1'b0, 32'h200, 8'h00, 64'h0, 1'b0, "oor_rd");
    do_req(1'b0, 32'h0, 8'h00, 64'h0, 1'b0, "rd0_after_oor");

    do_req(1'b1, 32'h08, 8'hFF, 64'h0101010101010101, 1'b0, "wr1");
    do_req(1'b1, 32'h18, 8'hFF, 64'h0303030303030303, 1'b0, "wr3");
    do_req(1'b0, 32'h08, 8'h00, 64'h0, 1'b0, "b2b1");
    do_req(1'b0, 32'h10, 8'h00, 64'h0, 1'b0, "b2b2");
    do_req(1'b0, 32'h18, 8'h00, 64'h0, 1'b0, "b2b3");

    do_req(1'b0, 32'h10, 8'h00, 64'h0, 1'b1, "clr_rd2");
    chk("clr/busy_now", 64'(bus.busy), 64'd1);
    wait_clear("clr");
    do_req(1'b0, 32'h10, 8'h00, 64'h0, 1'b0, "rd2_cleared");

    do_req(1'b1, 32'h28, 8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0, "wr5");
    do_req(1'b0, 32'h28, 8'h00, 64'h0, 1'b1, "clr_rd5");
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 64'h0;
    wait_clear("rst_in_clear");
    do_req(1'b0, 32'h28, 8'h00, 64'h0, 1'b0, "rd5_cleared");

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_chk("rnd");
      end else begin
        if ($urandom_range(0, 19) == 0) addr = $urandom;
        else addr = $urandom_range(0, 71) * 8 + $urandom_range(0, 7);
        wd = {$urandom, $urandom};
        do_req(1'($urandom_range(0, 1)), addr, 8'($urandom), wd, 1'b0, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
